mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_resp_pkg.sv | 16 +
 rtl/mem_resp_array.sv | 23 ++
 rtl/mem_responder.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and widths for the fixed-latency memory responder.
// Optional feature macro: MEM_ERR_CHECK_EN (error transactions).
package mem_resp_pkg;

    localparam int DW = 32;
    localparam int AW = 26;
    localparam int CW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/mem_resp_array.sv
// Word storage: synchronous write, combinational read, no reset.
// Optional feature macro: none.
module mem_resp_array #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] idx_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem_q [2**DEPTH_LOG2];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder with IDLE/WAIT/RESP/DONE handshake.
// Optional feature macro: MEM_ERR_CHECK_EN (flag bad requests via ERR).
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int LATENCY    = 3,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          READ,
    input  logic          WRITE,
    input  logic [AW-1:0] ADDR,
    input  logic [DW-1:0] DATA_IN,
    output logic [DW-1:0] DATA_OUT,
    output logic          READY,
    output logic          BUSY,
    output logic          ERR
);

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [DW-1:0]         data_q, data_d;
    logic [DW-1:0]         dout_q, dout_d;
    logic                  wr_q, wr_d;
    logic                  err_q, err_d;
    logic                  we;
    logic [DW-1:0]         rdata;
    logic                  accept;
    logic                  req_err;

`ifdef MEM_ERR_CHECK_EN
    // Conflicting ops or out-of-range addresses become error transactions.
    assign accept  = READ | WRITE;
    assign req_err = (READ & WRITE) | ((ADDR >> DEPTH_LOG2) != '0);
`else
    logic unused_addr_hi;
    assign unused_addr_hi = |(ADDR >> DEPTH_LOG2);
    assign accept  = READ ^ WRITE;
    assign req_err = 1'b0;
`endif

    mem_resp_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk_i  (CLK),
        .we_i   (we),
        .idx_i  (idx_q),
        .wdata_i(data_q),
        .rdata_o(rdata)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            dout_q  <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            dout_q  <= dout_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        dout_d  = dout_q;
        wr_d    = wr_q;
        err_d   = err_q;
        we      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = WAIT;
                    cnt_d   = CW'(LATENCY - 1);
                    idx_d   = ADDR[DEPTH_LOG2-1:0];
                    data_d  = DATA_IN;
                    wr_d    = WRITE;
                    err_d   = req_err;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    // Storage and DATA_OUT update on the edge into RESP.
                    if (!err_q) begin
                        if (wr_q) begin
                            we = 1'b1;
                        end else begin
                            dout_d = rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = DONE;
            end
            DONE: begin
                if (!READ && !WRITE) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign DATA_OUT = dout_q;
    assign READY    = (state_q == RESP);
    assign BUSY     = (state_q == WAIT) || (state_q == RESP);
    assign ERR      = (state_q == RESP) && err_q;

endmodule
